// File: rtl/prefetcher_data_queue.sv
// In-order request/data buffer for the prefetcher: entries are allocated on issued reads,
// filled in order by single-beat responses, and popped only from the head on a demand hit.
module prefetcher_data_queue #(
  parameter int ADDR_BITS          = 64,
  parameter int DATA_BITS          = 64,
  parameter int LOG_DEPTH          = 3,
  parameter int ALMOST_FULL_MARGIN = 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 flushN,
  input  logic                 allocValid,
  input  logic [ADDR_BITS-1:0] allocAddr,
  output logic                 allocReady,
  input  logic                 respValid,
  input  logic [DATA_BITS-1:0] respData,
  output logic                 respReady,
  input  logic                 lookupValid,
  input  logic [ADDR_BITS-1:0] lookupAddr,
  output logic                 prefetcherHit,
  output logic                 readValid,
  output logic [DATA_BITS-1:0] readData,
  output logic [LOG_DEPTH:0]   outstandingReqCnt,
  output logic                 almostFull,
  output logic                 empty
);

  localparam int DEPTH     = 1 << LOG_DEPTH;
  localparam int PW        = LOG_DEPTH + 1;
  // Wide enough to absorb several back-to-back flushes of a full queue.
  localparam int DROP_BITS = 16;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_THR  = PW'(DEPTH - ALMOST_FULL_MARGIN);

  logic [PW-1:0]        head_q, head_d, fill_q, fill_d, alloc_q, alloc_d;
  logic [DROP_BITS-1:0] drop_q, drop_d;
  logic [DEPTH-1:0]     filled_q, filled_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;

  logic [ADDR_BITS-1:0] addr_mem [DEPTH];
  logic [DATA_BITS-1:0] data_mem [DEPTH];

  logic [PW-1:0]        occupancy, pending;
  logic [LOG_DEPTH-1:0] head_idx, fill_idx, alloc_idx, wr_idx;
  logic                 full, drop_busy, alloc_en, fill_en, pop_en, mem_we;

  assign occupancy = alloc_q - head_q;
  assign pending   = alloc_q - fill_q;
  assign full      = (occupancy == DEPTH_P);
  assign drop_busy = (drop_q != '0);
  assign head_idx  = head_q[LOG_DEPTH-1:0];
  assign fill_idx  = fill_q[LOG_DEPTH-1:0];
  assign alloc_idx = alloc_q[LOG_DEPTH-1:0];

  assign empty             = (occupancy == '0);
  assign allocReady        = !full;
  assign almostFull        = (occupancy >= AF_THR);
  assign outstandingReqCnt = pending;
  assign respReady         = (pending != '0) || drop_busy;
  assign prefetcherHit     = !empty && (addr_mem[head_idx] == lookupAddr);
  assign readValid         = rd_valid_q;
  assign readData          = rd_data_q;

  assign alloc_en = allocValid && !full;
  assign fill_en  = respValid && !drop_busy && (pending != '0);
  assign pop_en   = lookupValid && prefetcherHit && filled_q[head_idx];
  // A flush empties the queue, so an allocation in that cycle lands in entry 0.
  assign mem_we   = flushN ? alloc_en : allocValid;
  assign wr_idx   = flushN ? alloc_idx : '0;

  // NOTE: every signal driven here gets a default first, otherwise a path that skips
  // an assignment would infer a latch.
  always_comb begin
    head_d     = head_q;
    fill_d     = fill_q;
    alloc_d    = alloc_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (!flushN) begin
      head_d   = '0;
      fill_d   = '0;
      filled_d = '0;
      alloc_d  = allocValid ? PW'(1) : '0;
      // Every request still outstanding will answer later; a response now retires one.
      drop_d   = drop_q + DROP_BITS'(pending);
      if (respValid && (drop_d != '0)) drop_d = drop_d - DROP_BITS'(1);
    end else begin
      if (alloc_en) begin
        filled_d[alloc_idx] = 1'b0;
        alloc_d             = alloc_q + PW'(1);
      end
      if (fill_en) begin
        filled_d[fill_idx] = 1'b1;
        fill_d             = fill_q + PW'(1);
      end
      if (respValid && drop_busy) drop_d = drop_q - DROP_BITS'(1);
      if (pop_en) begin
        head_d     = head_q + PW'(1);
        rd_valid_d = 1'b1;
        rd_data_d  = data_mem[head_idx];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking assignments belong only in the combinational block above.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head_q     <= '0;
      fill_q     <= '0;
      alloc_q    <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      fill_q     <= fill_d;
      alloc_q    <= alloc_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // NOTE: the entry storage has no reset; the filled bits and pointers guard every read.
  always_ff @(posedge clk) begin
    if (mem_we) addr_mem[wr_idx] <= allocAddr;
    if (fill_en && flushN) data_mem[fill_idx] <= respData;
  end

endmodule

// File: tb/tb_prefetcher_data_queue.sv
// Directed bench for prefetcher_data_queue; popped data is checked against a scoreboard
// queue filled when a popping lookup is driven.
module tb_prefetcher_data_queue;

  logic        clk = 1'b0;
  logic        resetN, flushN;
  logic        allocValid, respValid, lookupValid;
  logic [63:0] allocAddr, respData, lookupAddr;
  logic        allocReady, respReady, prefetcherHit, readValid, almostFull, empty;
  logic [63:0] readData;
  logic [3:0]  outstandingReqCnt;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] exp_q[$];

  prefetcher_data_queue dut (
    .clk(clk), .resetN(resetN), .flushN(flushN),
    .allocValid(allocValid), .allocAddr(allocAddr), .allocReady(allocReady),
    .respValid(respValid), .respData(respData), .respReady(respReady),
    .lookupValid(lookupValid), .lookupAddr(lookupAddr), .prefetcherHit(prefetcherHit),
    .readValid(readValid), .readData(readData),
    .outstandingReqCnt(outstandingReqCnt), .almostFull(almostFull), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    flushN = 1'b1; allocValid = 1'b0; respValid = 1'b0; lookupValid = 1'b0;
  endtask

  // Advance one cycle; a pop driven in the previous cycle must show up now.
  task automatic tick();
    logic want;
    want = (exp_q.size() != 0);
    @(posedge clk);
    #1;
    check("read_valid", readValid, want);
    if (want) check("read_data", readData, exp_q.pop_front());
  endtask

  task automatic do_alloc(input logic [63:0] a);
    allocValid = 1'b1; allocAddr = a;
  endtask

  task automatic do_resp(input logic [63:0] d);
    respValid = 1'b1; respData = d;
  endtask

  task automatic do_lookup(input logic [63:0] a);
    lookupValid = 1'b1; lookupAddr = a;
  endtask

  function automatic logic [63:0] sa(input int k);
    return 64'h2000 + 64'(k) * 64'h40;
  endfunction

  function automatic logic [63:0] sd(input int k);
    return 64'hDA7A_5EED_0000_0000 | 64'(k * 7 + 3);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    resetN = 1'b0; allocAddr = '0; respData = '0; lookupAddr = '0;
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_alloc_ready", allocReady, 1'b1);
    check("rst_almost_full", almostFull, 1'b0);
    check("rst_resp_ready", respReady, 1'b0);
    check("rst_outstanding", outstandingReqCnt, 4'd0);
    check("rst_hit", prefetcherHit, 1'b0);
    check("rst_read_valid", readValid, 1'b0);
    check("rst_read_data", readData, 64'h0);
    #10 resetN = 1'b1;
    tick();

    // Three allocations, miss/unfilled-hit lookups, then fills and in-order pops.
    do_alloc(64'h100); tick();
    do_alloc(64'h140); tick();
    do_alloc(64'h180); tick();
    idle(); #1;
    check("basic_outstanding3", outstandingReqCnt, 4'd3);
    check("basic_not_empty", empty, 1'b0);
    check("basic_resp_ready", respReady, 1'b1);
    do_lookup(64'h200); #1;
    check("miss_hit", prefetcherHit, 1'b0);
    tick();
    do_lookup(64'h100); #1;
    check("unfilled_hit", prefetcherHit, 1'b1);
    tick();
    do_resp(64'hD0); tick();
    check("unfilled_still_hit", prefetcherHit, 1'b1);
    do_resp(64'hD1); exp_q.push_back(64'hD0); tick();
    do_resp(64'hD2); do_lookup(64'h140); exp_q.push_back(64'hD1); tick();
    respValid = 1'b0; #1;
    check("basic_outstanding0", outstandingReqCnt, 4'd0);
    do_lookup(64'h180); exp_q.push_back(64'hD2); tick();
    idle(); #1;
    check("basic_drained", empty, 1'b1);

    // Fill to the almost-full threshold, then to full, then an ignored ninth alloc.
    for (int i = 0; i < 7; i++) begin
      do_alloc(sa(100 + i)); tick();
      if (i == 5) check("af_below", almostFull, 1'b0);
    end
    idle(); #1;
    check("af_at7", almostFull, 1'b1);
    check("ready_at7", allocReady, 1'b1);
    check("outstanding7", outstandingReqCnt, 4'd7);
    do_alloc(sa(107)); tick();
    idle(); #1;
    check("full_not_ready", allocReady, 1'b0);
    check("outstanding8", outstandingReqCnt, 4'd8);
    do_alloc(64'hDEAD); tick();
    idle(); #1;
    check("ninth_ignored", outstandingReqCnt, 4'd8);
    for (int i = 0; i < 8; i++) begin
      do_resp(sd(100 + i)); tick();
    end
    idle(); tick();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 0) do_alloc(64'h9999);
      do_lookup(sa(100 + i)); exp_q.push_back(sd(100 + i)); tick();
      if (i == 0) check("pop_while_full_occ7", almostFull, 1'b1);
    end
    idle(); #1;
    check("full_pop_alloc_ignored", empty, 1'b1);

    // Flush with three outstanding, a same-cycle response and a same-cycle alloc.
    do_alloc(64'h500); tick();
    do_alloc(64'h540); tick();
    do_alloc(64'h580); tick();
    idle(); flushN = 1'b0; do_resp(64'hBAD0); do_alloc(64'h400); tick();
    idle(); #1;
    check("flush_outstanding", outstandingReqCnt, 4'd1);
    check("flush_not_empty", empty, 1'b0);
    do_resp(64'hBAD1); do_lookup(64'h400); #1;
    check("flush_head_hit", prefetcherHit, 1'b1);
    tick();
    check("drop1_outstanding", outstandingReqCnt, 4'd1);
    do_resp(64'hBAD2); tick();
    check("drop2_outstanding", outstandingReqCnt, 4'd1);
    do_resp(64'h4444); tick();
    respValid = 1'b0; #1;
    check("flush_fill_outstanding", outstandingReqCnt, 4'd0);
    exp_q.push_back(64'h4444); tick();
    idle(); #1;
    check("flush_drained_empty", empty, 1'b1);
    check("flush_resp_ready", respReady, 1'b0);

    // Steady occupancy of four for twenty cycles; pointers wrap more than once.
    for (int k = 0; k < 4; k++) begin
      idle(); do_alloc(sa(k)); tick();
    end
    for (int k = 0; k < 3; k++) begin
      idle(); do_resp(sd(k)); tick();
    end
    idle(); tick();
    for (int i = 0; i < 20; i++) begin
      idle();
      do_lookup(sa(i)); exp_q.push_back(sd(i));
      do_alloc(sa(i + 4));
      do_resp(sd(i + 3));
      tick();
      if (i % 5 == 4) begin
        check("steady_outstanding", outstandingReqCnt, 4'd1);
        check("steady_not_af", almostFull, 1'b0);
      end
    end
    for (int j = 0; j < 4; j++) begin
      idle();
      if (j == 0) do_resp(sd(23));
      do_lookup(sa(20 + j)); exp_q.push_back(sd(20 + j));
      tick();
    end
    idle(); #1;
    check("steady_drained", empty, 1'b1);

    // Asynchronous reset with four pending entries.
    for (int k = 0; k < 4; k++) begin
      idle(); do_alloc(64'h7000 + 64'(k)); tick();
    end
    idle(); do_lookup(64'h7000);
    @(posedge clk); #2;
    resetN = 1'b0; #1;
    check("arst_empty", empty, 1'b1);
    check("arst_outstanding", outstandingReqCnt, 4'd0);
    check("arst_resp_ready", respReady, 1'b0);
    check("arst_alloc_ready", allocReady, 1'b1);
    check("arst_hit", prefetcherHit, 1'b0);
    check("arst_read_data", readData, 64'h0);
    check("arst_read_valid", readValid, 1'b0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    #10 resetN = 1'b1;
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
